// File: rtl/axis_pkt_pkg.sv
// Shared widths, beat layout and FSM encoding for the AXI-Stream packetizer.
package axis_pkt_pkg;

  localparam int unsigned TDATA_WIDTH_DEF = 8;
  localparam int unsigned LEN_WIDTH_DEF   = 8;
  localparam int unsigned CNT_WIDTH_DEF   = 16;

  // One output beat as stored in the skid buffer / downstream FIFO word.
  typedef struct packed {
    logic                       tkeep;
    logic                       tlast;
    logic [TDATA_WIDTH_DEF-1:0] tdata;
  } axis_beat_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered output stage plus one overflow entry.
// Ports:
//   aclk, aresetn      clock, async active-low reset
//   s_valid/s_ready    upstream handshake (s_ready registered, = !skid occupied)
//   s_data             upstream word
//   m_valid/m_ready    downstream handshake
//   m_data             downstream word (held while stalled)
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             in_xfer;
  logic             load_main;

  assign in_xfer   = s_valid & s_ready;
  // Output register may take a new word when empty or being drained this edge.
  assign load_main = ~m_valid | m_ready;

  // Datapath and handshake registers; s_ready never sees m_ready combinationally.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      s_ready    <= 1'b0;
    end else if (load_main) begin
      if (skid_valid) begin
        // s_ready was low, so no input can arrive alongside the skid drain.
        m_data     <= skid_data;
        m_valid    <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        m_valid <= in_xfer;
        if (in_xfer) begin
          m_data <= s_data;
        end
      end
      s_ready <= 1'b1;
    end else if (in_xfer) begin
      skid_data  <= s_data;
      skid_valid <= 1'b1;
      s_ready    <= 1'b0;
    end else begin
      s_ready <= ~skid_valid;
    end
  end

endmodule

// File: rtl/axis_packetizer.sv
// Splits a tlast-less AXI-Stream into packets of pkt_len_i beats (0 => 1),
// tags the final beat with tlast and counts packets leaving the block.
// Ports:
//   aclk, aresetn                   clock, async active-low reset
//   s_axis_tvalid/tready/tdata      input stream
//   pkt_len_i                       packet length, sampled at packet start
//   m_axis_tvalid/tready/tdata      output stream
//   m_axis_tlast, m_axis_tkeep      packet end marker, constant keep
//   pkt_count_o                     completed output packets (wrapping)
module axis_packetizer
  import axis_pkt_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = TDATA_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH   = LEN_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [LEN_WIDTH-1:0]   pkt_len_i,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tkeep,
  output logic [CNT_WIDTH-1:0]   pkt_count_o
);

  // Beat word layout matches axis_beat_t: {tkeep, tlast, tdata}.
  localparam int unsigned BEAT_WIDTH = TDATA_WIDTH + 2;

  pkt_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  len_in;
  logic [LEN_WIDTH-1:0]  cnt_inc;
  logic                  beat_last;
  logic                  in_xfer;
  logic [BEAT_WIDTH-1:0] beat_in;
  logic [BEAT_WIDTH-1:0] beat_out;

  assign in_xfer = s_axis_tvalid & s_axis_tready;
  assign len_in  = (pkt_len_i == '0) ? LEN_WIDTH'(1) : pkt_len_i;
  assign cnt_inc = cnt_q + LEN_WIDTH'(1);

  // Beat-count FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Next-state and tlast tagging of the beat being accepted.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    beat_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_xfer) begin
          if (len_in == LEN_WIDTH'(1)) begin
            beat_last = 1'b1;
          end else begin
            len_d   = len_in;
            cnt_d   = LEN_WIDTH'(1);
            state_d = ST_IN_PKT;
          end
        end
      end
      ST_IN_PKT: begin
        if (in_xfer) begin
          if (cnt_inc == len_q) begin
            beat_last = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign beat_in = {1'b1, beat_last, s_axis_tdata};

  axis_skid_buffer #(
    .WIDTH (BEAT_WIDTH)
  ) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .s_data  (beat_in),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (beat_out)
  );

  assign m_axis_tkeep = beat_out[BEAT_WIDTH-1];
  assign m_axis_tlast = beat_out[TDATA_WIDTH];
  assign m_axis_tdata = beat_out[TDATA_WIDTH-1:0];

  // Completed-packet counter, wraps naturally.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_count_o <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      pkt_count_o <= pkt_count_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axis_packetizer.sv
// Bench for axis_packetizer: directed vector table, reset sequences and
// randomized streaming against a queue-based packet model.
module tb_axis_packetizer;
  import axis_pkt_pkg::*;

  localparam int unsigned TW = 8;
  localparam int unsigned LW = 8;
  localparam int unsigned CW = 16;

  logic          aclk;
  logic          aresetn;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [TW-1:0] s_axis_tdata;
  logic [LW-1:0] pkt_len_i;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tkeep;
  logic [CW-1:0] pkt_count_o;

  axis_packetizer #(
    .TDATA_WIDTH (TW),
    .LEN_WIDTH   (LW),
    .CNT_WIDTH   (CW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .pkt_len_i     (pkt_len_i),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep),
    .pkt_count_o   (pkt_count_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [TW-1:0] data;
    logic          last;
  } exp_beat_t;

  exp_beat_t     exp_q[$];
  int unsigned   pkt_pos   = 0;
  int unsigned   pkt_size  = 1;
  logic [CW-1:0] exp_cnt   = '0;
  logic          prev_stall = 1'b0;
  logic [TW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  // Sample between edges; handshakes seen here complete on the next rising edge.
  always @(negedge aclk) begin
    exp_beat_t e;
    if (!aresetn) begin
      check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_m_tdata",  32'(m_axis_tdata),  32'd0);
      check("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
      check("rst_m_tkeep",  32'(m_axis_tkeep),  32'd0);
      check("rst_s_tready", 32'(s_axis_tready), 32'd0);
      check("rst_pkt_count", 32'(pkt_count_o),  32'd0);
      exp_q.delete();
      pkt_pos    = 0;
      exp_cnt    = '0;
      prev_stall = 1'b0;
    end else begin
      check("pkt_count", 32'(pkt_count_o), 32'(exp_cnt));
      if (m_axis_tvalid) check("tkeep", 32'(m_axis_tkeep), 32'd1);
      if (prev_stall) begin
        check("stall_valid", 32'(m_axis_tvalid), 32'd1);
        check("stall_data",  32'(m_axis_tdata),  32'(prev_data));
        check("stall_last",  32'(m_axis_tlast),  32'(prev_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(m_axis_tdata), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(m_axis_tdata), 32'(e.data));
          check("out_last", 32'(m_axis_tlast), 32'(e.last));
          if (e.last) exp_cnt = exp_cnt + CW'(1);
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        // Packet size is fixed by the length seen on the packet's first beat.
        if (pkt_pos == 0) pkt_size = (pkt_len_i == 0) ? 1 : int'(pkt_len_i);
        pkt_pos++;
        e.data = s_axis_tdata;
        e.last = (pkt_pos == pkt_size);
        if (e.last) pkt_pos = 0;
        exp_q.push_back(e);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [TW-1:0] data;
    logic [LW-1:0] len;
    logic          last;
  } vec_t;

  vec_t vec[$];

  function automatic void add(input logic [TW-1:0] d, input logic [LW-1:0] l, input logic t);
    vec_t v;
    v.data = d;
    v.len  = l;
    v.last = t;
    vec.push_back(v);
  endfunction

  // One beat per cycle with m_axis_tready high; each beat must appear exactly one cycle later.
  task automatic run_vectors(input int lo, input int hi);
    m_axis_tready = 1'b1;
    for (int i = lo; i <= hi + 1; i++) begin
      @(posedge aclk); #1;
      if (i <= hi) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = vec[i].data;
        pkt_len_i     = vec[i].len;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      @(negedge aclk);
      if (i > lo) begin
        check("vec_valid", 32'(m_axis_tvalid), 32'd1);
        check("vec_data",  32'(m_axis_tdata),  32'(vec[i-1].data));
        check("vec_last",  32'(m_axis_tlast),  32'(vec[i-1].last));
      end
      if (i <= hi) check("vec_s_ready", 32'(s_axis_tready), 32'd1);
    end
    @(posedge aclk); #1;
    @(negedge aclk);
  endtask

  task automatic reset_dut();
    @(posedge aclk); #3;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check("rst_async_valid", 32'(m_axis_tvalid), 32'd0);
    check("rst_async_last",  32'(m_axis_tlast),  32'd0);
    check("rst_async_ready", 32'(s_axis_tready), 32'd0);
    check("rst_async_count", 32'(pkt_count_o),   32'd0);
    repeat (2) @(negedge aclk);
    #2;
    aresetn = 1'b1;
    #1;
    check("ready_before_edge", 32'(s_axis_tready), 32'd0);
    @(posedge aclk); #1;
    check("ready_after_edge", 32'(s_axis_tready), 32'd1);
  endtask

  // Streams nbeats consecutive data values with random valid/ready duty.
  task automatic stream(input int nbeats, input int vpct, input int rpct,
                        input int max_cycles, input logic [TW-1:0] base);
    int   sent = 0;
    int   cyc  = 0;
    logic acc  = 1'b0;
    s_axis_tvalid = 1'b0;
    while (sent < nbeats && cyc < max_cycles) begin
      @(posedge aclk); #1;
      cyc++;
      if (acc) s_axis_tvalid = 1'b0;
      if (!s_axis_tvalid && sent < nbeats && $urandom_range(99) < vpct) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = TW'(base + TW'(sent));
      end
      m_axis_tready = ($urandom_range(99) < rpct);
      @(negedge aclk);
      acc = s_axis_tvalid && s_axis_tready;
      if (acc) sent++;
    end
    check("stream_all_sent", 32'(sent), 32'(nbeats));
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
  endtask

  initial begin
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    pkt_len_i     = 8'd4;
    m_axis_tready = 1'b1;

    // 0..11: length 4, 0x01..0x0C
    for (int i = 1; i <= 12; i++) add(TW'(i), 8'd4, (i % 4) == 0);
    // 12..14: length 0, 0, 1 -> every beat is a packet
    add(8'h21, 8'd0, 1'b1);
    add(8'h22, 8'd0, 1'b1);
    add(8'h23, 8'd1, 1'b1);
    // 15..23: length 5, switched to 2 after beat 2
    add(8'h31, 8'd5, 1'b0);
    add(8'h32, 8'd5, 1'b0);
    add(8'h33, 8'd2, 1'b0);
    add(8'h34, 8'd2, 1'b0);
    add(8'h35, 8'd2, 1'b1);
    add(8'h36, 8'd2, 1'b0);
    add(8'h37, 8'd2, 1'b1);
    add(8'h38, 8'd2, 1'b0);
    add(8'h39, 8'd2, 1'b1);
    // 24..25: first half of an interrupted length-4 packet
    add(8'h51, 8'd4, 1'b0);
    add(8'h52, 8'd4, 1'b0);
    // 26..29: full packet after reset
    add(8'h41, 8'd4, 1'b0);
    add(8'h42, 8'd4, 1'b0);
    add(8'h43, 8'd4, 1'b0);
    add(8'h44, 8'd4, 1'b1);

    repeat (3) @(negedge aclk);
    #2;
    aresetn = 1'b1;
    #1;
    check("ready_before_edge", 32'(s_axis_tready), 32'd0);
    @(posedge aclk); #1;
    check("ready_after_edge", 32'(s_axis_tready), 32'd1);

    run_vectors(0, 11);
    check("len4_count", 32'(pkt_count_o), 32'd3);
    run_vectors(12, 14);
    check("len01_count", 32'(pkt_count_o), 32'd6);
    run_vectors(15, 23);
    check("lenchg_count", 32'(pkt_count_o), 32'd9);

    // Reset in mid-packet, then a fresh 4-beat packet.
    run_vectors(24, 25);
    reset_dut();
    run_vectors(26, 29);
    check("after_rst_count", 32'(pkt_count_o), 32'd1);

    // Random backpressure, length 3, 300 beats.
    reset_dut();
    pkt_len_i = 8'd3;
    stream(300, 80, 50, 5000, 8'h00);
    check("rand_count", 32'(pkt_count_o), 32'd100);

    // Single-beat packets past the counter wrap.
    reset_dut();
    pkt_len_i = 8'd1;
    stream(65537, 100, 100, 70000, 8'h80);
    check("wrap_count", 32'(pkt_count_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
